pair_triple_gen: RTL and testbench
==================================

PAIR_TRIPLE_GEN -- requirements
Module: pair_triple_gen

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port req_val, input, 1 bit: a request is present.
REQ-004 SHALL have port req_rdy, output, 1 bit: the block can accept a request.
REQ-005 SHALL have port req_mode, input, 2 bits: requested pattern class.
- 0: no-detect patterns (zero or one bit set).
- 1: exact pair.
- 2: triple.
- 3: any detect (pair or triple).
REQ-006 SHALL have port req_len, input, 4 bits: number of vectors to emit; 0 means 16.
REQ-007 SHALL have ports out0, out1, out2, outputs, 1 bit each: emitted 3-bit vector, bit-compatible with the detector inputs in0, in1, in2.
REQ-008 SHALL have port out_val, output, 1 bit: out0..out2 hold a valid vector.
REQ-009 SHALL have port out_rdy, input, 1 bit: the consumer accepts the vector.
REQ-010 SHALL have port out_last, output, 1 bit: the current valid vector is the final one of the request.

Function
REQ-011 SHALL implement FSM states IDLE and EMIT.
- req_rdy = 1 exactly when in IDLE and rst = 0.
- out_val = 1 exactly when in EMIT.
REQ-012 SHALL accept a request on a clock edge with req_val & req_rdy in IDLE.
- On acceptance: latch req_mode, load remaining = req_len (0 loads 16), clear index to 0, enter EMIT.
- First out_val occurs the next cycle (1-cycle latency).
REQ-013 SHALL emit vectors in {out2,out1,out0} order as follows; index wraps modulo the class size.
- mode 0: 000, 001, 010, 100.
- mode 1: 011, 101, 110.
- mode 2: 111.
- mode 3: 011, 101, 110, 111.
REQ-014 SHALL complete a transfer on each edge with out_val & out_rdy: index advances, remaining decrements.
REQ-015 SHALL hold out0..out2 and out_last stable while out_val = 1 and out_rdy = 0.
REQ-016 SHALL drive out_last = 1 exactly when remaining = 1 in EMIT.
- A transfer with out_last = 1 returns the FSM to IDLE, so req_rdy = 1 the following cycle (one idle bubble minimum between requests).
REQ-017 SHALL ignore req_val, req_mode and req_len while in EMIT.
REQ-018 SHALL ignore out_rdy while in IDLE.
REQ-019 SHALL drive out0..out2 = 000 and out_last = 0 whenever out_val = 0.

Reset
REQ-020 SHALL, on a clock edge with rst = 1, force IDLE, index 0 and remaining 0, aborting any request mid-stream with no further vectors.
REQ-021 SHALL hold req_rdy = 0, out_val = 0, out_last = 0 and out0..out2 = 000 while rst = 1.
REQ-022 SHALL clear the statistics counter to 0 on reset when it is present.

Configuration
REQ-023 SHALL, with macro PAIR_TRIPLE_GEN_STATS_EN defined, add output port stat_cnt, 8 bits.
- stat_cnt increments by 1 on each completed out_val & out_rdy transfer.
- It wraps 255 -> 0.
REQ-024 SHALL, without PAIR_TRIPLE_GEN_STATS_EN, omit port stat_cnt and its register entirely, with all other behaviour identical.

Structure
REQ-025 SHALL take the mode encodings (MODE_NODET = 0, MODE_PAIR = 1, MODE_TRIPLE = 2, MODE_DETECT = 3) and the FSM state encodings as named constants from the shared misc include file.
REQ-026 SHALL place the mode/index-to-vector table of REQ-013, including the class-size lookup, in one combinational sub-module, pair_triple_pattern_rom.

Verification
REQ-027 SHALL cover: reset, then req_mode = 1, req_len = 4, out_rdy = 1 -> vectors 011, 101, 110, 011 on four consecutive cycles; out_last only on the 4th; req_rdy = 1 the next cycle.
REQ-028 SHALL cover: req_mode = 2, req_len = 0, out_rdy = 1 -> 16 vectors of 111; out_last on the 16th.
REQ-029 SHALL cover: req_mode = 0, req_len = 3, out_rdy low for 3 cycles after the first out_val -> 000 held stable 3 cycles, then 001, 010 with out_last on 010.
REQ-030 SHALL cover: req_val pulsed with new req_mode during EMIT -> no effect on the emitted sequence; req_rdy stays 0.
REQ-031 SHALL cover: rst = 1 after the 2nd transfer of a req_len = 8 request -> out_val = 0 the next cycle, then req_rdy = 1 once rst = 0; a new mode 3 request restarts at 011.
REQ-032 SHALL cover, with PAIR_TRIPLE_GEN_STATS_EN defined: 260 completed transfers -> stat_cnt = 4; reset -> stat_cnt = 0.

Source files
------------

// File: rtl/pair_triple_gen_pkg.sv
// rtl/pair_triple_gen_pkg.sv - shared mode and FSM state encodings for pair_triple_gen
package pair_triple_gen_pkg;

    typedef enum logic [1:0] {
        MODE_NODET  = 2'd0,
        MODE_PAIR   = 2'd1,
        MODE_TRIPLE = 2'd2,
        MODE_DETECT = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam int unsigned REM_W = 5;

endpackage

// File: rtl/pair_triple_pattern_rom.sv
// rtl/pair_triple_pattern_rom.sv - mode/index to {out2,out1,out0} vector table and class size
module pair_triple_pattern_rom
    import pair_triple_gen_pkg::*;
(
    input  mode_e       mode_i,
    input  logic [1:0]  idx_i,
    output logic [2:0]  vec_o,
    output logic [2:0]  size_o
);

    always_comb begin
        vec_o  = 3'b000;
        size_o = 3'd1;
        case (mode_i)
            MODE_NODET: begin
                size_o = 3'd4;
                case (idx_i)
                    2'd0:    vec_o = 3'b000;
                    2'd1:    vec_o = 3'b001;
                    2'd2:    vec_o = 3'b010;
                    default: vec_o = 3'b100;
                endcase
            end
            MODE_PAIR: begin
                size_o = 3'd3;
                case (idx_i)
                    2'd0:    vec_o = 3'b011;
                    2'd1:    vec_o = 3'b101;
                    default: vec_o = 3'b110;
                endcase
            end
            MODE_TRIPLE: begin
                size_o = 3'd1;
                vec_o  = 3'b111;
            end
            default: begin
                size_o = 3'd4;
                case (idx_i)
                    2'd0:    vec_o = 3'b011;
                    2'd1:    vec_o = 3'b101;
                    2'd2:    vec_o = 3'b110;
                    default: vec_o = 3'b111;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/pair_triple_gen.sv
// rtl/pair_triple_gen.sv - request-driven pair/triple test vector generator
// Optional transfer counter port stat_cnt under PAIR_TRIPLE_GEN_STATS_EN.
module pair_triple_gen
    import pair_triple_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic [1:0]  req_mode,
    input  logic [3:0]  req_len,
    output logic        out0,
    output logic        out1,
    output logic        out2,
    output logic        out_val,
    input  logic        out_rdy,
    output logic        out_last
`ifdef PAIR_TRIPLE_GEN_STATS_EN
    ,
    output logic [7:0]  stat_cnt
`endif
);

    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [1:0]        idx_q, idx_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [2:0]        pat_vec;
    logic [2:0]        pat_size;

    pair_triple_pattern_rom u_rom (
        .mode_i (mode_q),
        .idx_i  (idx_q),
        .vec_o  (pat_vec),
        .size_o (pat_size)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (req_val) begin
                    mode_d  = mode_e'(req_mode);
                    rem_d   = (req_len == 4'd0) ? REM_W'(16) : {1'b0, req_len};
                    idx_d   = 2'd0;
                    state_d = ST_EMIT;
                end
            end
            default: begin
                if (out_rdy) begin
                    rem_d = rem_q - REM_W'(1);
                    // Index wraps at the class size so short classes repeat.
                    idx_d = (({1'b0, idx_q} + 3'd1) == pat_size) ? 2'd0 : idx_q + 2'd1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_NODET;
            idx_q   <= 2'd0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

    assign req_rdy            = (state_q == ST_IDLE) && !rst;
    assign out_val            = (state_q == ST_EMIT) && !rst;
    assign out_last           = out_val && (rem_q == REM_W'(1));
    assign {out2, out1, out0} = out_val ? pat_vec : 3'b000;

`ifdef PAIR_TRIPLE_GEN_STATS_EN
    logic [7:0] stat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt_q <= 8'd0;
        end else if (out_val && out_rdy) begin
            stat_cnt_q <= stat_cnt_q + 8'd1;
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_pair_triple_gen.sv
// tb/tb_pair_triple_gen.sv - directed self-checking bench for pair_triple_gen
module tb_pair_triple_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_val;
    logic       req_rdy;
    logic [1:0] req_mode;
    logic [3:0] req_len;
    logic       out0, out1, out2;
    logic       out_val;
    logic       out_rdy;
    logic       out_last;
`ifdef PAIR_TRIPLE_GEN_STATS_EN
    logic [7:0] stat_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pair_triple_gen dut (
        .clk      (clk),
        .rst      (rst),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_mode (req_mode),
        .req_len  (req_len),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_last (out_last)
`ifdef PAIR_TRIPLE_GEN_STATS_EN
        ,
        .stat_cnt (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] mode, input logic [3:0] len);
        req_val  = 1'b1;
        req_mode = mode;
        req_len  = len;
        step();
        req_val  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_val = 1'b0; req_mode = 2'd0; req_len = 4'd0; out_rdy = 1'b1;
        step();
        step();
        n_cmp++;
        if ({req_rdy, out_val, out_last, out2, out1, out0} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_hold: got rdy/val/last/vec=%b required 000000",
                     {req_rdy, out_val, out_last, out2, out1, out0});
        end
`ifdef PAIR_TRIPLE_GEN_STATS_EN
        n_cmp++;
        if (stat_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_stat: got %0d required 0", stat_cnt);
        end
`endif
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_rdy !== 1'b1 || out_val !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b val=%b required rdy=1 val=0", req_rdy, out_val);
        end
    endtask

    task automatic test_pair();
        logic [2:0] exp_v [4];
        exp_v[0] = 3'b011; exp_v[1] = 3'b101; exp_v[2] = 3'b110; exp_v[3] = 3'b011;
        out_rdy = 1'b1;
        accept(2'd1, 4'd4);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_val !== 1'b1 || {out2, out1, out0} !== exp_v[i] || out_last !== (i == 3)) begin
                n_err++;
                $display("FAIL pair_vec%0d: got val=%b vec=%b last=%b required val=1 vec=%b last=%b",
                         i, out_val, {out2, out1, out0}, out_last, exp_v[i], (i == 3));
            end
            step();
        end
        n_cmp++;
        if (req_rdy !== 1'b1 || out_val !== 1'b0 || {out2, out1, out0} !== 3'b000) begin
            n_err++;
            $display("FAIL pair_done: got rdy=%b val=%b vec=%b required rdy=1 val=0 vec=000",
                     req_rdy, out_val, {out2, out1, out0});
        end
    endtask

    task automatic test_triple_len16();
        out_rdy = 1'b1;
        accept(2'd2, 4'd0);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (out_val !== 1'b1 || {out2, out1, out0} !== 3'b111 || out_last !== (i == 15)) begin
                n_err++;
                $display("FAIL triple_vec%0d: got val=%b vec=%b last=%b required val=1 vec=111 last=%b",
                         i, out_val, {out2, out1, out0}, out_last, (i == 15));
            end
            step();
        end
        n_cmp++;
        if (out_val !== 1'b0 || req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL triple_done: got val=%b rdy=%b required val=0 rdy=1", out_val, req_rdy);
        end
    endtask

    task automatic test_stall();
        out_rdy = 1'b0;
        accept(2'd0, 4'd3);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_val !== 1'b1 || {out2, out1, out0} !== 3'b000 || out_last !== 1'b0 || req_rdy !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d: got val=%b vec=%b last=%b rdy=%b required val=1 vec=000 last=0 rdy=0",
                         i, out_val, {out2, out1, out0}, out_last, req_rdy);
            end
            step();
        end
        out_rdy = 1'b1;
        #1;
        n_cmp++;
        if ({out2, out1, out0} !== 3'b000 || out_val !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got val=%b vec=%b required val=1 vec=000", out_val, {out2, out1, out0});
        end
        step();
        n_cmp++;
        if ({out2, out1, out0} !== 3'b001 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL stall_v1: got vec=%b last=%b required vec=001 last=0", {out2, out1, out0}, out_last);
        end
        step();
        n_cmp++;
        if ({out2, out1, out0} !== 3'b010 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL stall_v2: got vec=%b last=%b required vec=010 last=1", {out2, out1, out0}, out_last);
        end
        step();
    endtask

    task automatic test_ignore_req();
        logic [2:0] exp_v [3];
        exp_v[0] = 3'b011; exp_v[1] = 3'b101; exp_v[2] = 3'b110;
        out_rdy = 1'b1;
        accept(2'd1, 4'd3);
        for (int i = 0; i < 3; i++) begin
            req_val  = (i == 0);
            req_mode = 2'd2;
            req_len  = 4'd5;
            #1;
            n_cmp++;
            if (req_rdy !== 1'b0 || {out2, out1, out0} !== exp_v[i] || out_last !== (i == 2)) begin
                n_err++;
                $display("FAIL ignore_vec%0d: got rdy=%b vec=%b last=%b required rdy=0 vec=%b last=%b",
                         i, req_rdy, {out2, out1, out0}, out_last, exp_v[i], (i == 2));
            end
            step();
            req_val = 1'b0;
        end
        n_cmp++;
        if (out_val !== 1'b0 || req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL ignore_done: got val=%b rdy=%b required val=0 rdy=1", out_val, req_rdy);
        end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b1;
        accept(2'd0, 4'd8);
        step();
        step();
        n_cmp++;
        if ({out2, out1, out0} !== 3'b010 || out_val !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: got val=%b vec=%b required val=1 vec=010", out_val, {out2, out1, out0});
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (out_val !== 1'b0 || req_rdy !== 1'b0 || {out2, out1, out0} !== 3'b000) begin
            n_err++;
            $display("FAIL mid_rst: got val=%b rdy=%b vec=%b required val=0 rdy=0 vec=000",
                     out_val, req_rdy, {out2, out1, out0});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_rdy !== 1'b1 || out_val !== 1'b0) begin
            n_err++;
            $display("FAIL mid_release: got rdy=%b val=%b required rdy=1 val=0", req_rdy, out_val);
        end
        accept(2'd3, 4'd2);
        n_cmp++;
        if ({out2, out1, out0} !== 3'b011 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL mid_restart0: got vec=%b last=%b required vec=011 last=0", {out2, out1, out0}, out_last);
        end
        step();
        n_cmp++;
        if ({out2, out1, out0} !== 3'b101 || out_last !== 1'b1) begin
            n_err++;
            $display("FAIL mid_restart1: got vec=%b last=%b required vec=101 last=1", {out2, out1, out0}, out_last);
        end
        step();
    endtask

    task automatic test_detect_wrap();
        logic [2:0] exp_v [6];
        exp_v[0] = 3'b011; exp_v[1] = 3'b101; exp_v[2] = 3'b110;
        exp_v[3] = 3'b111; exp_v[4] = 3'b011; exp_v[5] = 3'b101;
        out_rdy = 1'b1;
        accept(2'd3, 4'd6);
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({out2, out1, out0} !== exp_v[i] || out_last !== (i == 5)) begin
                n_err++;
                $display("FAIL detect_vec%0d: got vec=%b last=%b required vec=%b last=%b",
                         i, {out2, out1, out0}, out_last, exp_v[i], (i == 5));
            end
            step();
        end
    endtask

`ifdef PAIR_TRIPLE_GEN_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_rdy = 1'b1;
        for (int r = 0; r < 16; r++) begin
            accept(2'd3, 4'd0);
            for (int i = 0; i < 16; i++) step();
        end
        accept(2'd1, 4'd4);
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (stat_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL stat_wrap: got %0d required 4", stat_cnt);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (stat_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL stat_reset: got %0d required 0", stat_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pair();
        test_triple_len16();
        test_stall();
        test_ignore_req();
        test_reset_mid();
        test_detect_wrap();
`ifdef PAIR_TRIPLE_GEN_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
